// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
// Holds alignment-mode encodings, counter direction and the duty-bus slicing helper.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // LSB position of channel ch inside a packed CHANNELS*width duty bus.
    function automatic int duty_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: active duty register, counter compare, polarity and output flop.
// The duty takes its new value in the same cycle the top signals an update.
module pwm_cmp_ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             down_i,
    input  logic             apply_i,
    input  logic [WIDTH-1:0] duty_src_i,
    input  logic             polarity_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_eff;
    logic             raw;
    logic             pwm_q;

    // On the descending half the compare is inclusive, so a centre-aligned pulse
    // covers duty clocks on each side of cnt==0 (2*duty in total).
    always_comb begin
        duty_eff = apply_i ? duty_src_i : duty_q;
        raw      = 1'b0;
        if (en_i) begin
            raw = down_i ? (cnt_i <= duty_eff) : (cnt_i < duty_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_eff;
            pwm_q  <= raw ^ polarity_i;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared up/up-down period counter, double-buffered
// period/duty/mode updates applied at period boundaries, per-channel compare.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               CHANNELS   = DEF_CHANNELS,
    parameter logic [WIDTH-1:0] PERIOD_RST = 8'd255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      mode_in,
    input  logic [CHANNELS-1:0]       polarity,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      cycle_start
);

    dir_e                      state_q, state_d;
    dir_e                      dir_cur;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]          period_q, period_d;
    logic                      mode_q, mode_d;
    logic [WIDTH-1:0]          pend_period_q, pend_period_d;
    logic [CHANNELS*WIDTH-1:0] pend_duty_q, pend_duty_d;
    logic                      pend_mode_q, pend_mode_d;
    logic                      pend_valid_q, pend_valid_d;
    logic                      cycle_start_q;

    logic                      boundary;
    logic                      apply;
    logic [CHANNELS*WIDTH-1:0] duty_src;

    // A load in the boundary cycle bypasses the pending registers; with the
    // counter stopped, anything pending is taken over on the next clock.
    always_comb begin
        boundary      = en && (cnt_q == '0);
        apply         = (load || pend_valid_q) && (boundary || !en);
        duty_src      = load ? duty_in : pend_duty_q;
        period_d      = period_q;
        mode_d        = mode_q;
        if (apply) begin
            period_d = load ? period_in : pend_period_q;
            mode_d   = load ? mode_in : pend_mode_q;
        end
        pend_period_d = load ? period_in : pend_period_q;
        pend_duty_d   = load ? duty_in : pend_duty_q;
        pend_mode_d   = load ? mode_in : pend_mode_q;
        if (apply) begin
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_valid_d = 1'b1;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Counter/direction FSM; runs against the period and mode that govern this cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_cur = (apply && (mode_d != mode_q)) ? DIR_UP : state_q;
        if (!en) begin
            cnt_d   = '0;
            state_d = DIR_UP;
        end else if (mode_d == MODE_EDGE) begin
            state_d = DIR_UP;
            cnt_d   = (cnt_q >= period_d) ? '0 : cnt_q + 1'b1;
        end else begin
            case (dir_cur)
                DIR_UP: begin
                    if (cnt_q >= period_d) begin
                        if (period_d == '0) begin
                            cnt_d   = '0;
                            state_d = DIR_UP;
                        end else begin
                            cnt_d   = cnt_q - 1'b1;
                            state_d = DIR_DOWN;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = DIR_UP;
                    end
                end
                DIR_DOWN: begin
                    if (cnt_q <= {{(WIDTH-1){1'b0}}, 1'b1}) begin
                        cnt_d   = '0;
                        state_d = DIR_UP;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = DIR_DOWN;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = DIR_UP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= DIR_UP;
            cnt_q         <= '0;
            period_q      <= PERIOD_RST;
            mode_q        <= MODE_EDGE;
            pend_period_q <= '0;
            pend_duty_q   <= '0;
            pend_mode_q   <= MODE_EDGE;
            pend_valid_q  <= 1'b0;
            cycle_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            mode_q        <= mode_d;
            pend_period_q <= pend_period_d;
            pend_duty_q   <= pend_duty_d;
            pend_mode_q   <= pend_mode_d;
            pend_valid_q  <= pend_valid_d;
            cycle_start_q <= boundary;
        end
    end

    assign cycle_start = cycle_start_q;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            pwm_cmp_ch #(
                .WIDTH(WIDTH)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .en_i      (en),
                .cnt_i     (cnt_q),
                .down_i    (state_q == DIR_DOWN),
                .apply_i   (apply),
                .duty_src_i(duty_src[duty_lsb(gi, WIDTH) +: WIDTH]),
                .polarity_i(polarity[gi]),
                .pwm_o     (pwm_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: per-period output patterns are captured
// starting at each cycle_start and compared with hand-computed values.
module tb_pwm_multi_ch;

    localparam int W  = 8;
    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          load;
    logic [W-1:0]  period_in;
    logic [CH*W-1:0] duty_in;
    logic          mode_in;
    logic [CH-1:0] polarity;
    logic [CH-1:0] pwm_out;
    logic          cycle_start;

    int            total = 0;
    int            bad   = 0;
    int            idx;
    int            plen;
    logic [31:0]   pat [CH];
    int            hi  [CH];

    always #5 clk = ~clk;

    pwm_multi_ch #(
        .WIDTH(W),
        .CHANNELS(CH),
        .PERIOD_RST(8'd255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .period_in  (period_in),
        .duty_in    (duty_in),
        .mode_in    (mode_in),
        .polarity   (polarity),
        .pwm_out    (pwm_out),
        .cycle_start(cycle_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic record();
        for (int c = 0; c < CH; c++) begin
            if (idx < 32) pat[c][idx] = pwm_out[c];
            if (pwm_out[c]) hi[c]++;
        end
        idx++;
    endtask

    task automatic begin_period();
        for (int c = 0; c < CH; c++) begin
            pat[c] = '0;
            hi[c]  = 0;
        end
        idx = 0;
        record();
    endtask

    task automatic adv();
        step();
        record();
    endtask

    task automatic run_to_cs(output int len);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            step();
            if (cycle_start) got = 1'b1;
            else record();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL run_to_cs_timeout got=no_cycle_start exp=cycle_start");
        end
        len = idx;
    endtask

    task automatic sync_cs();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            step();
            if (cycle_start) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL sync_cs_timeout got=no_cycle_start exp=cycle_start");
        end
    endtask

    task automatic set_load(input logic [W-1:0] p, input logic m,
                            input logic [W-1:0] d2, input logic [W-1:0] d1,
                            input logic [W-1:0] d0);
        period_in = p;
        mode_in   = m;
        duty_in   = {d2, d1, d0};
        load      = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b0; polarity = '0;
        period_in = '0; duty_in = '0; mode_in = 1'b0;
        repeat (3) step();
        total++;
        if (pwm_out !== 3'b000) begin bad++; $display("FAIL reset_pwm got=%b exp=000", pwm_out); end
        total++;
        if (cycle_start !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b exp=0", cycle_start); end
        rst = 1'b0;
        step();
        total++;
        if (cycle_start !== 1'b1) begin bad++; $display("FAIL reset_first_cs got=%b exp=1", cycle_start); end
        begin_period();
        run_to_cs(plen);
        total++;
        if (plen !== 256) begin bad++; $display("FAIL reset_period got=%0d exp=256", plen); end
        for (int c = 0; c < CH; c++) begin
            total++;
            if (hi[c] !== 0) begin bad++; $display("FAIL reset_duty ch%0d got=%0d exp=0", c, hi[c]); end
        end
        $display("test_reset: period=%0d highs=%0d/%0d/%0d", plen, hi[0], hi[1], hi[2]);
    endtask

    task automatic test_edge();
        set_load(8'd9, 1'b0, 8'd10, 8'd5, 8'd2);
        step();
        load = 1'b0;
        sync_cs();
        begin_period();
        run_to_cs(plen);
        total++;
        if (plen !== 10) begin bad++; $display("FAIL edge_period got=%0d exp=10", plen); end
        total++;
        if (pat[0] !== 32'h0000_0003) begin bad++; $display("FAIL edge_ch0 got=%h exp=00000003", pat[0]); end
        total++;
        if (pat[1] !== 32'h0000_001F) begin bad++; $display("FAIL edge_ch1 got=%h exp=0000001f", pat[1]); end
        total++;
        if (pat[2] !== 32'h0000_03FF) begin bad++; $display("FAIL edge_ch2 got=%h exp=000003ff", pat[2]); end
        begin_period();
        run_to_cs(plen);
        total++;
        if (plen !== 10) begin bad++; $display("FAIL edge_period2 got=%0d exp=10", plen); end
        $display("test_edge: period=%0d pat=%h/%h/%h", plen, pat[0], pat[1], pat[2]);
    endtask

    task automatic test_center();
        set_load(8'd8, 1'b1, 8'd9, 8'd1, 8'd3);
        step();
        load = 1'b0;
        sync_cs();
        begin_period();
        run_to_cs(plen);
        total++;
        if (plen !== 16) begin bad++; $display("FAIL center_period got=%0d exp=16", plen); end
        total++;
        if (pat[0] !== 32'h0000_E007) begin bad++; $display("FAIL center_ch0 got=%h exp=0000e007", pat[0]); end
        total++;
        if (pat[1] !== 32'h0000_8001) begin bad++; $display("FAIL center_ch1 got=%h exp=00008001", pat[1]); end
        total++;
        if (pat[2] !== 32'h0000_FFFF) begin bad++; $display("FAIL center_ch2 got=%h exp=0000ffff", pat[2]); end
        $display("test_center: period=%0d pat=%h/%h/%h", plen, pat[0], pat[1], pat[2]);
    endtask

    task automatic test_glitch_free();
        set_load(8'd9, 1'b0, 8'd0, 8'd5, 8'd5);
        step();
        load = 1'b0;
        sync_cs();
        begin_period();
        repeat (3) adv();
        set_load(8'd9, 1'b0, 8'd0, 8'd5, 8'd2);
        adv();
        load = 1'b0;
        run_to_cs(plen);
        total++;
        if (plen !== 10) begin bad++; $display("FAIL glitch_period got=%0d exp=10", plen); end
        total++;
        if (pat[0] !== 32'h0000_001F) begin bad++; $display("FAIL glitch_keep got=%h exp=0000001f", pat[0]); end
        begin_period();
        run_to_cs(plen);
        total++;
        if (pat[0] !== 32'h0000_0003) begin bad++; $display("FAIL glitch_next got=%h exp=00000003", pat[0]); end
        total++;
        if (pat[1] !== 32'h0000_001F) begin bad++; $display("FAIL glitch_ch1 got=%h exp=0000001f", pat[1]); end
        $display("test_glitch_free: next pat=%h/%h/%h", pat[0], pat[1], pat[2]);
    endtask

    task automatic test_back_to_back();
        // load while the counter sits at 0 takes effect in that same period
        begin_period();
        repeat (9) adv();
        set_load(8'd9, 1'b0, 8'd0, 8'd5, 8'd4);
        step();
        load = 1'b0;
        total++;
        if (cycle_start !== 1'b1) begin bad++; $display("FAIL coincide_cs got=%b exp=1", cycle_start); end
        begin_period();
        run_to_cs(plen);
        total++;
        if (pat[0] !== 32'h0000_000F) begin bad++; $display("FAIL coincide_duty got=%h exp=0000000f", pat[0]); end
        // two loads in one period: only the later one is seen
        begin_period();
        adv();
        set_load(8'd9, 1'b0, 8'd0, 8'd5, 8'd3);
        adv();
        load = 1'b0;
        repeat (2) adv();
        set_load(8'd9, 1'b0, 8'd0, 8'd5, 8'd7);
        adv();
        load = 1'b0;
        run_to_cs(plen);
        total++;
        if (pat[0] !== 32'h0000_000F) begin bad++; $display("FAIL multiload_cur got=%h exp=0000000f", pat[0]); end
        begin_period();
        run_to_cs(plen);
        total++;
        if (pat[0] !== 32'h0000_007F) begin bad++; $display("FAIL multiload_next got=%h exp=0000007f", pat[0]); end
        total++;
        if (plen !== 10) begin bad++; $display("FAIL multiload_period got=%0d exp=10", plen); end
        $display("test_back_to_back: pat0=%h period=%0d", pat[0], plen);
    endtask

    task automatic test_polarity_enable_reset();
        en = 1'b0;
        polarity = 3'b101;
        repeat (2) step();
        total++;
        if (pwm_out !== 3'b101) begin bad++; $display("FAIL disabled_pol got=%b exp=101", pwm_out); end
        total++;
        if (cycle_start !== 1'b0) begin bad++; $display("FAIL disabled_cs got=%b exp=0", cycle_start); end
        polarity = 3'b000;
        en = 1'b1;
        sync_cs();
        begin_period();
        repeat (2) adv();
        set_load(8'd3, 1'b0, 8'd0, 8'd0, 8'd1);
        adv();
        load = 1'b0;
        adv();
        rst = 1'b1;
        step();
        total++;
        if (pwm_out !== 3'b000) begin bad++; $display("FAIL midrst_pwm got=%b exp=000", pwm_out); end
        total++;
        if (cycle_start !== 1'b0) begin bad++; $display("FAIL midrst_cs got=%b exp=0", cycle_start); end
        rst = 1'b0;
        step();
        total++;
        if (cycle_start !== 1'b1) begin bad++; $display("FAIL midrst_restart got=%b exp=1", cycle_start); end
        begin_period();
        run_to_cs(plen);
        total++;
        if (plen !== 256) begin bad++; $display("FAIL midrst_period got=%0d exp=256", plen); end
        total++;
        if (hi[0] !== 0) begin bad++; $display("FAIL midrst_duty got=%0d exp=0", hi[0]); end
        $display("test_polarity_enable_reset: period=%0d", plen);
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_glitch_free();
        test_back_to_back();
        test_polarity_enable_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
